// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready handshake, configurable baud divider, width and stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit between the data and stop bits.

module uart_tx_param #(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 TxD,
    output logic                 busy
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    localparam bit PARAMS_OK = (CLK_DIV >= 2) && (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                               ((STOP_BITS == 1) || (STOP_BITS == 2)) &&
                               ((PARITY_ODD == 0) || (PARITY_ODD == 1));

    // Legal parameter ranges are documented here; an illegal set adds no hardware.
    if (!PARAMS_OK) begin : g_illegal_params
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [CW-1:0]        baudCnt_q, baudCnt_d;
    logic [BW-1:0]        bitCnt_q, bitCnt_d;
    logic                 stopCnt_q, stopCnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic bitEnd;
    logic lastStop;
    logic readyNow;
    logic accept;

    assign bitEnd   = (baudCnt_q == BAUD_LAST);
    assign lastStop = (STOP_BITS == 1) || stopCnt_q;
    // Ready in the final cycle of the last stop bit lets the next frame start with no idle gap.
    assign readyNow = (state_q == IDLE) || ((state_q == STOP) && bitEnd && lastStop);
    assign accept   = tx_valid && readyNow;

    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitCnt_d  = bitCnt_q;
        stopCnt_d = stopCnt_q;
        shreg_d   = shreg_q;
        txd_d     = txd_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != IDLE) begin
            baudCnt_d = bitEnd ? '0 : baudCnt_q + 1'b1;
        end
        case (state_q)
            START: begin
                if (bitEnd) begin
                    txd_d    = shreg_q[0];
                    state_d  = DATA;
                    bitCnt_d = '0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shreg_d  = {1'b0, shreg_q[DATA_BITS-1:1]};
                    bitCnt_d = bitCnt_q + 1'b1;
                    if (bitCnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = parity_q;
`else
                        state_d   = STOP;
                        txd_d     = 1'b1;
                        stopCnt_d = 1'b0;
`endif
                    end else begin
                        txd_d = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    state_d   = STOP;
                    txd_d     = 1'b1;
                    stopCnt_d = 1'b0;
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    if (lastStop) begin
                        state_d = IDLE;
                    end else begin
                        stopCnt_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // An accept overrides whatever the current frame would have done on this edge.
        if (accept) begin
            shreg_d   = tx_data;
            txd_d     = 1'b0;
            baudCnt_d = '0;
            bitCnt_d  = '0;
            state_d   = START;
`ifdef UART_TX_PARITY_EN
            parity_d  = (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
            shreg_q   <= '0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitCnt_q  <= bitCnt_d;
            stopCnt_q <= stopCnt_d;
            shreg_q   <= shreg_d;
            txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign TxD      = txd_q;
    assign busy     = (state_q != IDLE);
    assign tx_ready = readyNow;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances cover the 8N1, 5-bit and two-stop-bit (even/odd parity) setups.
// Expected frames follow UART_TX_PARITY_EN the same way the design does.

module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] validV;
    logic [3:0] txdV;
    logic [3:0] busyV;
    logic [3:0] readyV;
    logic [7:0] dataA;
    logic [4:0] dataB;
    logic [7:0] dataC;
    logic [7:0] dataD;
    int         sel;
    int         vectors;
    int         miscompares;

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) uA (
        .clk(clk), .reset(reset), .tx_valid(validV[0]), .tx_data(dataA),
        .tx_ready(readyV[0]), .TxD(txdV[0]), .busy(busyV[0]));

    uart_tx_param #(.CLK_DIV(3), .DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(0)) uB (
        .clk(clk), .reset(reset), .tx_valid(validV[1]), .tx_data(dataB),
        .tx_ready(readyV[1]), .TxD(txdV[1]), .busy(busyV[1]));

    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) uC (
        .clk(clk), .reset(reset), .tx_valid(validV[2]), .tx_data(dataC),
        .tx_ready(readyV[2]), .TxD(txdV[2]), .busy(busyV[2]));

    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) uD (
        .clk(clk), .reset(reset), .tx_valid(validV[3]), .tx_data(dataD),
        .tx_ready(readyV[3]), .TxD(txdV[3]), .busy(busyV[3]));

    // Line level for each bit slot of a frame, slot 0 being the start bit.
    function automatic logic [15:0] buildFrame(input logic [7:0] data, input int dataBits,
                                               input int stopBits, input bit parityOdd);
        logic [15:0] f;
        int          k;
        logic        p;
        f = '0;
        k = 1;
        p = parityOdd;
        for (int i = 0; i < dataBits; i++) begin
            f[k] = data[i];
            p    = p ^ data[i];
            k++;
        end
        if (PAR_EN) begin
            f[k] = p;
            k++;
        end
        for (int i = 0; i < stopBits; i++) begin
            f[k] = 1'b1;
            k++;
        end
        return f;
    endfunction

    function automatic int frameBits(input int dataBits, input int stopBits);
        return 1 + dataBits + (PAR_EN ? 1 : 0) + stopBits;
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic setData(input logic [7:0] d);
        case (sel)
            0:       dataA = d;
            1:       dataB = d[4:0];
            2:       dataC = d;
            default: dataD = d;
        endcase
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        @(negedge clk);
        setData(d);
        validV[sel] = 1'b1;
        checkOutput($sformatf("inst%0d ready before accept", sel), readyV[sel], 1'b1);
        @(posedge clk);
    endtask

    // Follows a frame cycle by cycle from just after its accept edge through its final edge.
    task automatic watchFrame(input string tag, input logic [7:0] d, input int dataBits,
                              input int stopBits, input bit parityOdd, input int div,
                              input bit chain, input logic [7:0] nextData, input int pulseAt);
        logic [15:0] f;
        int          n;
        f = buildFrame(d, dataBits, stopBits, parityOdd);
        n = frameBits(dataBits, stopBits) * div;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checkOutput($sformatf("%s TxD c%0d", tag, c), txdV[sel], f[c / div]);
            checkOutput($sformatf("%s busy c%0d", tag, c), busyV[sel], 1'b1);
            checkOutput($sformatf("%s ready c%0d", tag, c), readyV[sel], (c == n - 1));
            if (c == 0) begin
                if (chain) setData(nextData);
                else validV[sel] = 1'b0;
            end
            if (pulseAt >= 0 && c == pulseAt) begin
                setData(8'hFF);
                validV[sel] = 1'b1;
            end
            if (pulseAt >= 0 && c == pulseAt + 1) begin
                validV[sel] = 1'b0;
            end
        end
        @(posedge clk);
    endtask

    task automatic checkIdle(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            checkOutput($sformatf("%s TxD", tag), txdV[sel], 1'b1);
            checkOutput($sformatf("%s busy", tag), busyV[sel], 1'b0);
            checkOutput($sformatf("%s ready", tag), readyV[sel], 1'b1);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sel         = 0;
        validV      = '0;
        dataA       = '0;
        dataB       = '0;
        dataC       = '0;
        dataD       = '0;
        reset       = 1'b1;

        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("inst%0d reset TxD", i), txdV[i], 1'b1);
            checkOutput($sformatf("inst%0d reset busy", i), busyV[i], 1'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkIdle("post-reset", 2);

        sel = 0;
        applyStimulus(8'hA5);
        watchFrame("single A5", 8'hA5, 8, 1, 1'b0, 4, 1'b0, 8'h00, -1);
        checkIdle("after A5", 2);

        applyStimulus(8'h00);
        watchFrame("b2b 00", 8'h00, 8, 1, 1'b0, 4, 1'b1, 8'hFF, -1);
        watchFrame("b2b FF", 8'hFF, 8, 1, 1'b0, 4, 1'b0, 8'h00, -1);
        checkIdle("after b2b", 2);

        sel = 1;
        applyStimulus(8'h13);
        watchFrame("width5 10011", 8'h13, 5, 1, 1'b0, 3, 1'b0, 8'h00, -1);
        checkIdle("after width5", 2);

        sel = 2;
        applyStimulus(8'hA5);
        watchFrame("stop2 even A5", 8'hA5, 8, 2, 1'b0, 4, 1'b0, 8'h00, -1);
        checkIdle("after stop2 even", 2);

        sel = 3;
        applyStimulus(8'hA5);
        watchFrame("stop2 odd A5", 8'hA5, 8, 2, 1'b1, 4, 1'b0, 8'h00, -1);
        checkIdle("after stop2 odd", 2);

        sel = 0;
        applyStimulus(8'h81);
        watchFrame("holdoff 81", 8'h81, 8, 1, 1'b0, 4, 1'b0, 8'h00, 20);
        checkIdle("holdoff no accept", 3);

        applyStimulus(8'hA5);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) validV[0] = 1'b0;
        end
        checkOutput("midframe data bit3 TxD", txdV[0], 1'b0);
        checkOutput("midframe busy", busyV[0], 1'b1);
        #1 reset = 1'b1;
        #1;
        checkOutput("async reset TxD", txdV[0], 1'b1);
        checkOutput("async reset busy", busyV[0], 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkIdle("after midframe reset", 2);
        applyStimulus(8'h3C);
        watchFrame("post-reset 3C", 8'h3C, 8, 1, 1'b0, 4, 1'b0, 8'h00, -1);
        checkIdle("after 3C", 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
